// File: rtl/xdma_c2h_stream_arbiter_pkg.sv
// Shared types and constants for the XDMA C2H two-port stream arbiter.
//   arb_state_e : arbiter owner state (IDLE / BUSY0 / BUSY1)
//   arb_pick    : round-robin arbitration function on the two tvalids
//   grant_of    : one-hot grant vector for a state
package xdma_c2h_arb_pkg;

    localparam int unsigned C2H_DATA_WIDTH = 512;
    localparam int unsigned C2H_KEEP_WIDTH = 64;
    localparam int unsigned C2H_USER_WIDTH = 1;
    localparam int unsigned PKT_CNT_WIDTH  = 32;

    localparam int unsigned PORT_UDP  = 0;
    localparam int unsigned PORT_PERF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

    // Single valid wins; on contention the port not granted last time wins.
    function automatic arb_state_e arb_pick(input logic v0, input logic v1, input logic rr_last);
        arb_state_e pick;
        pick = IDLE;
        if (v0 && v1) begin
            pick = rr_last ? BUSY0 : BUSY1;
        end else if (v0) begin
            pick = BUSY0;
        end else if (v1) begin
            pick = BUSY1;
        end
        return pick;
    endfunction

    function automatic logic [1:0] grant_of(input arb_state_e s);
        logic [1:0] g;
        g = '0;
        if (s == BUSY0) g[PORT_UDP]  = 1'b1;
        if (s == BUSY1) g[PORT_PERF] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/xdma_c2h_stream_arbiter_axis_out_reg.sv
// Single-stage valid/ready output register (full throughput, no skid).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_payload   : beat offered by the arbiter
//   in_ready              : register can take a beat this cycle
//   out_valid/out_payload : registered beat towards the sink
//   out_ready             : sink ready
module axis_out_reg #(
    parameter int unsigned WIDTH = 578
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_payload,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload,
    input  logic             out_ready
);

    // Load whenever the held beat is empty or being consumed.
    assign in_ready = !out_valid || out_ready;

    // Payload only changes when a real beat is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_payload <= in_payload;
            end
        end
    end

endmodule

// File: rtl/xdma_c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the XDMA C2H AXI-Stream input
// between UDP RX (port 0) and perf reports (port 1).
//   xdma_clk, xdma_reset : clock, synchronous active-high reset
//   s0_axis_*            : port 0 (UDP RX) slave stream
//   s1_axis_*            : port 1 (perf report) slave stream
//   m_axis_*             : registered master stream to XDMA s_axis_c2h
//   grant_out            : one-hot current owner, 0 when idle
//   pkt_cnt0/1           : packets forwarded per port (wrapping)
module xdma_c2h_stream_arbiter
    import xdma_c2h_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = C2H_DATA_WIDTH,
    parameter int unsigned KEEP_WIDTH = C2H_KEEP_WIDTH,
    parameter int unsigned USER_WIDTH = C2H_USER_WIDTH
) (
    input  logic                     xdma_clk,
    input  logic                     xdma_reset,
    input  logic                     s0_axis_tvalid,
    output logic                     s0_axis_tready,
    input  logic                     s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s0_axis_tkeep,
    input  logic [USER_WIDTH-1:0]    s0_axis_tuser,
    input  logic                     s1_axis_tvalid,
    output logic                     s1_axis_tready,
    input  logic                     s1_axis_tlast,
    input  logic [DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s1_axis_tkeep,
    input  logic [USER_WIDTH-1:0]    s1_axis_tuser,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic [1:0]               grant_out,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt0,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt1
);

    localparam int unsigned PAY_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    arb_state_e       state;
    arb_state_e       arb_next;
    logic             rr_last;
    logic             out_rdy;
    logic             acc0;
    logic             acc1;
    logic             last_acc;
    logic             beat_valid;
    logic [PAY_W-1:0] beat_payload;
    logic [PAY_W-1:0] out_payload;

    // Only the owner sees ready; depends on registered state and m_axis_tready only.
    assign s0_axis_tready = (state == BUSY0) && out_rdy;
    assign s1_axis_tready = (state == BUSY1) && out_rdy;

    assign acc0       = s0_axis_tvalid && s0_axis_tready;
    assign acc1       = s1_axis_tvalid && s1_axis_tready;
    assign last_acc   = (acc0 && s0_axis_tlast) || (acc1 && s1_axis_tlast);
    assign beat_valid = acc0 || acc1;
    assign arb_next   = arb_pick(s0_axis_tvalid, s1_axis_tvalid, rr_last);

    // Grant is exclusive, so the owner's beat is the only candidate.
    assign beat_payload = acc1
        ? {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast}
        : {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast};

    // Owner FSM, round-robin pointer and packet counters.
    always_ff @(posedge xdma_clk) begin
        if (xdma_reset) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            grant_out <= '0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
        end else begin
            // Re-arbitrate from idle or on the tlast beat, so packets go back-to-back.
            if ((state == IDLE) || last_acc) begin
                state     <= arb_next;
                grant_out <= grant_of(arb_next);
                if (arb_next == BUSY0) begin
                    rr_last <= 1'(PORT_UDP);
                end else if (arb_next == BUSY1) begin
                    rr_last <= 1'(PORT_PERF);
                end
            end
            if (acc0 && s0_axis_tlast) pkt_cnt0 <= pkt_cnt0 + PKT_CNT_WIDTH'(1);
            if (acc1 && s1_axis_tlast) pkt_cnt1 <= pkt_cnt1 + PKT_CNT_WIDTH'(1);
        end
    end

    axis_out_reg #(
        .WIDTH(PAY_W)
    ) u_out_reg (
        .clk        (xdma_clk),
        .rst        (xdma_reset),
        .in_valid   (beat_valid),
        .in_payload (beat_payload),
        .in_ready   (out_rdy),
        .out_valid  (m_axis_tvalid),
        .out_payload(out_payload),
        .out_ready  (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_payload;

endmodule

// File: tb/tb_xdma_c2h_stream_arbiter.sv
// Self-checking bench for xdma_c2h_stream_arbiter: AXI-Stream sources fed from
// beat queues, a cycle-level reference of the arbitration rules, and a per-port
// scoreboard that tracks every forwarded beat.
module tb_xdma_c2h_stream_arbiter;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          user;
        logic          last;
        int            gap;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sv [2];
    logic          sl [2];
    logic          su [2];
    logic [DW-1:0] sd [2];
    logic [KW-1:0] sk [2];
    logic          s0_rdy, s1_rdy;
    logic          m_valid, m_last, m_user, mr;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [1:0]    grant;
    logic [31:0]   pc0, pc1;

    always #5 clk = ~clk;

    xdma_c2h_stream_arbiter dut (
        .xdma_clk       (clk),
        .xdma_reset     (rst),
        .s0_axis_tvalid (sv[0]),
        .s0_axis_tready (s0_rdy),
        .s0_axis_tlast  (sl[0]),
        .s0_axis_tdata  (sd[0]),
        .s0_axis_tkeep  (sk[0]),
        .s0_axis_tuser  (su[0]),
        .s1_axis_tvalid (sv[1]),
        .s1_axis_tready (s1_rdy),
        .s1_axis_tlast  (sl[1]),
        .s1_axis_tdata  (sd[1]),
        .s1_axis_tkeep  (sk[1]),
        .s1_axis_tuser  (su[1]),
        .m_axis_tvalid  (m_valid),
        .m_axis_tlast   (m_last),
        .m_axis_tready  (mr),
        .m_axis_tdata   (m_data),
        .m_axis_tkeep   (m_keep),
        .m_axis_tuser   (m_user),
        .grant_out      (grant),
        .pkt_cnt0       (pc0),
        .pkt_cnt1       (pc1)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int mr_pct = 100;
    int stall_left = 0;
    int rise_cyc [2];
    int seq [2];
    int pushed [2];
    beat_t srcq [2][$];
    beat_t expq [2][$];
    int outlog_port [$];
    int outlog_cyc [$];

    // Reference state: owner (-1 none), last granted port, output register, counters.
    int            owner;
    int            rr;
    logic          mv_m, ml_m, mu_m;
    logic [DW-1:0] md_m;
    logic [KW-1:0] mk_m;
    int unsigned   cnt_m [2];

    logic          have_prev;
    logic          prev_v, prev_r, prev_l, prev_u;
    logic [DW-1:0] prev_d;
    logic [KW-1:0] prev_k;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_reset();
        owner = -1; rr = 1;
        mv_m = 1'b0; ml_m = 1'b0; mu_m = 1'b0; md_m = '0; mk_m = '0;
        cnt_m[0] = 0; cnt_m[1] = 0;
    endtask

    task automatic arbitrate();
        if (sv[0] && sv[1]) owner = 1 - rr;
        else if (sv[0])     owner = 0;
        else if (sv[1])     owner = 1;
        else                owner = -1;
        if (owner >= 0) rr = owner;
    endtask

    task automatic push_pkt(input int p, input int n, input int gap0, input int mid_idx, input int mid_gap);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.data        = rand_wide();
            b.data[31]    = (p == 1);
            b.data[30:0]  = 31'(seq[p]);
            seq[p]++;
            b.keep        = {$urandom(), $urandom()};
            b.user        = 1'($urandom_range(1));
            b.last        = (j == n - 1);
            b.gap         = (j == 0) ? gap0 : ((j == mid_idx) ? mid_gap : 0);
            srcq[p].push_back(b);
            expq[p].push_back(b);
        end
        pushed[p]++;
    endtask

    // One clock: check outputs at negedge, step the reference at posedge, drive at +1.
    task automatic tick();
        logic       rdy [2];
        logic       acc [2];
        logic [1:0] g_exp;
        beat_t      b;
        int         p;
        @(negedge clk);
        for (int i = 0; i < 2; i++) rdy[i] = (owner == i) && (!mv_m || mr);
        g_exp = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
        chk("m_tvalid", DW'(m_valid), DW'(mv_m));
        chk("grant", DW'(grant), DW'(g_exp));
        chk("s0_tready", DW'(s0_rdy), DW'(rdy[0]));
        chk("s1_tready", DW'(s1_rdy), DW'(rdy[1]));
        chk("pkt_cnt0", DW'(pc0), DW'(cnt_m[0]));
        chk("pkt_cnt1", DW'(pc1), DW'(cnt_m[1]));
        if (mv_m) begin
            chk("m_tdata", m_data, md_m);
            chk("m_tkeep", DW'(m_keep), DW'(mk_m));
            chk("m_tuser", DW'(m_user), DW'(mu_m));
            chk("m_tlast", DW'(m_last), DW'(ml_m));
        end
        if (have_prev && prev_v && !prev_r) begin
            chk("stall_valid", DW'(m_valid), DW'(1));
            chk("stall_data", m_data, prev_d);
            chk("stall_keep", DW'(m_keep), DW'(prev_k));
            chk("stall_user", DW'(m_user), DW'(prev_u));
            chk("stall_last", DW'(m_last), DW'(prev_l));
        end
        have_prev = 1'b1;
        prev_v = m_valid; prev_r = mr; prev_d = m_data; prev_k = m_keep; prev_u = m_user; prev_l = m_last;
        if (m_valid && mr) begin
            p = m_data[31] ? 1 : 0;
            if (expq[p].size() == 0) begin
                chk("sb_extra_beat", DW'(1), DW'(0));
            end else begin
                b = expq[p].pop_front();
                chk("sb_data", m_data, b.data);
                chk("sb_keep_user_last", DW'({m_keep, m_user, m_last}), DW'({b.keep, b.user, b.last}));
            end
            outlog_port.push_back(p);
            outlog_cyc.push_back(cyc);
        end
        for (int i = 0; i < 2; i++) acc[i] = sv[i] && rdy[i];
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (!mv_m || mr) begin
                mv_m = acc[0] || acc[1];
                for (int i = 0; i < 2; i++)
                    if (acc[i]) begin md_m = sd[i]; mk_m = sk[i]; mu_m = su[i]; ml_m = sl[i]; end
            end
            if (owner < 0) arbitrate();
            else if (acc[owner] && sl[owner]) begin cnt_m[owner]++; arbitrate(); end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                srcq[i].delete(); expq[i].delete(); sv[i] = 1'b0;
            end else begin
                if (acc[i]) begin void'(srcq[i].pop_front()); sv[i] = 1'b0; end
                if (!sv[i] && srcq[i].size() > 0) begin
                    if (srcq[i][0].gap > 0) srcq[i][0].gap = srcq[i][0].gap - 1;
                    else begin
                        sv[i] = 1'b1; sd[i] = srcq[i][0].data; sk[i] = srcq[i][0].keep;
                        su[i] = srcq[i][0].user; sl[i] = srcq[i][0].last;
                        if (rise_cyc[i] < 0) rise_cyc[i] = cyc;
                    end
                end
            end
            // Idle lanes carry garbage that must never be forwarded or counted.
            if (!sv[i]) begin
                sd[i] = rand_wide(); sk[i] = {$urandom(), $urandom()};
                su[i] = 1'($urandom_range(1)); sl[i] = 1'($urandom_range(1));
            end
        end
        if (rst) have_prev = 1'b0;
        if (stall_left > 0) begin mr = 1'b0; stall_left--; end
        else mr = ($urandom_range(99) < mr_pct);
    endtask

    task automatic clear_log();
        outlog_port.delete(); outlog_cyc.delete();
        rise_cyc[0] = -1; rise_cyc[1] = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        pushed[0] = 0; pushed[1] = 0;
        clear_log();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((srcq[0].size() + srcq[1].size() > 0 || mv_m) && n < budget) begin tick(); n++; end
        chk("drain_timeout", DW'(n >= budget), DW'(0));
        chk("sb_leftover", DW'(expq[0].size() + expq[1].size()), DW'(0));
    endtask

    task automatic wait_out(input int nbeats, input int budget);
        int n;
        n = 0;
        while (outlog_port.size() < nbeats && n < budget) begin tick(); n++; end
        chk("wait_out_timeout", DW'(n >= budget), DW'(0));
    endtask

    // Port of forwarded beat i is pat[i]; optionally require one beat per cycle.
    task automatic chk_order(input string tag, input int n, input logic [15:0] pat, input logic gapless);
        chk({tag, "_len"}, DW'(outlog_port.size()), DW'(n));
        for (int i = 0; i < n && i < outlog_port.size(); i++) begin
            chk({tag, "_port"}, DW'(outlog_port[i]), DW'(pat[i]));
            if (gapless && i > 0) chk({tag, "_bubble"}, DW'(outlog_cyc[i] - outlog_cyc[i-1]), DW'(1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; sl[i] = 1'b0; su[i] = 1'b0; sd[i] = '0; sk[i] = '0; seq[i] = 0; pushed[i] = 0;
        end
        model_reset();
        have_prev = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", DW'(m_valid), DW'(0));
        chk("rst_m_tlast", DW'(m_last), DW'(0));
        chk("rst_m_tdata", m_data, DW'(0));
        chk("rst_m_tkeep_tuser", DW'({m_keep, m_user}), DW'(0));
        chk("rst_grant", DW'(grant), DW'(0));
        chk("rst_counts", DW'({pc0, pc1}), DW'(0));
        chk("rst_treadys", DW'({s0_rdy, s1_rdy}), DW'(0));
        rst = 1'b0;

        // Single 3-beat packet on port 0, no contention.
        push_pkt(0, 3, 0, 0, 0);
        drain(50);
        chk_order("single", 3, 16'h0000, 1'b1);
        if (outlog_cyc.size() > 0) chk("single_latency", DW'(outlog_cyc[0] - rise_cyc[0]), DW'(2));
        chk("single_grant", DW'(grant), DW'(2'b01));
        chk("single_cnt0", DW'(pc0), DW'(1));

        // Simultaneous 2-beat packets: port 0 first, then port 1 with no bubble.
        do_reset();
        push_pkt(0, 2, 0, 0, 0);
        push_pkt(1, 2, 0, 0, 0);
        drain(50);
        chk_order("contend", 4, 16'b1100, 1'b1);
        chk("contend_cnts", DW'({pc0, pc1}), DW'({32'd1, 32'd1}));

        // Four 1-beat packets per port back-to-back: strict alternation.
        do_reset();
        for (int k = 0; k < 4; k++) begin push_pkt(0, 1, 0, 0, 0); push_pkt(1, 1, 0, 0, 0); end
        drain(80);
        chk_order("alternate", 8, 16'b1010_1010, 1'b1);
        chk("alternate_cnts", DW'({pc0, pc1}), DW'({32'd4, 32'd4}));

        // 5-cycle output stall in the middle of a 6-beat packet.
        do_reset();
        push_pkt(0, 6, 0, 0, 0);
        wait_out(2, 50);
        stall_left = 5;
        drain(80);
        chk_order("stall", 6, 16'h0000, 1'b0);
        chk("stall_cnt0", DW'(pc0), DW'(1));

        // Port 1 arrives during a port 0 packet with a 2-cycle tvalid gap.
        do_reset();
        push_pkt(0, 4, 0, 2, 2);
        push_pkt(1, 1, 2, 0, 0);
        drain(80);
        chk_order("no_preempt", 5, 16'b1_0000, 1'b0);
        if (outlog_cyc.size() == 5) chk("no_preempt_handover", DW'(outlog_cyc[4] - outlog_cyc[3]), DW'(1));

        // Reset while beat 2 of 4 is in the output register.
        do_reset();
        push_pkt(0, 1, 0, 0, 0);
        drain(50);
        push_pkt(0, 4, 0, 0, 0);
        wait_out(3, 50);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_m_tvalid", DW'(m_valid), DW'(0));
        chk("midrst_grant", DW'(grant), DW'(0));
        chk("midrst_counts", DW'({pc0, pc1}), DW'(0));
        clear_log();
        push_pkt(0, 2, 0, 0, 0);
        drain(50);
        chk_order("post_rst", 2, 16'h0000, 1'b1);
        chk("post_rst_cnt0", DW'(pc0), DW'(1));

        // Random traffic on both ports with random gaps and output backpressure.
        do_reset();
        mr_pct = 70;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 8) begin
                push_pkt(int'($urandom_range(1)), int'($urandom_range(6, 1)), int'($urandom_range(3)),
                         int'($urandom_range(5, 1)), int'($urandom_range(3)));
            end
            tick();
        end
        drain(3000);
        chk("rand_cnt0", DW'(pc0), DW'(pushed[0]));
        chk("rand_cnt1", DW'(pc1), DW'(pushed[1]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
